regfile_mp_scoreboard: RTL

//   Multi-port integer register file with a per-register busy scoreboard for the

---
 rtl/regfile_mp_scoreboard.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with per-register busy scoreboard.
// Combinational reads with optional same-cycle write forwarding; x0 optionally hard-wired to zero.
module regfile_mp_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs   [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [CNT_W-1:0]      cnt;

  logic [DEPTH-1:0]      wr_hit;
  logic [DATA_WIDTH-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]      set_mask;
  logic [DEPTH-1:0]      busy_next;
  logic                  cnt_inc;
  logic [CNT_W-1:0]      cnt_dec;
  logic [CNT_W-1:0]      cnt_next;

  function automatic logic valid_addr(input logic [ADDR_WIDTH-1:0] a);
    return !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int b = 0; b < DEPTH; b++) begin
      n = n + CNT_W'(v[b]);
    end
    return n;
  endfunction

  // Resolve write ports per register; ascending loop lets the highest port index win.
  always_comb begin
    wr_hit   = '0;
    set_mask = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j] && valid_addr(waddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
        wr_hit[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        wr_val[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (alloc_en && valid_addr(alloc_addr)) begin
      set_mask[alloc_addr] = 1'b1;
    end
  end

  // A new producer (alloc) overrides a same-cycle clear from writeback.
  always_comb begin
    busy_next = (busy & ~wr_hit) | set_mask;
    cnt_inc   = |(set_mask & ~busy);
    cnt_dec   = popcount(busy & wr_hit & ~set_mask);
    cnt_next  = cnt + CNT_W'(cnt_inc) - cnt_dec;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      busy <= busy_next;
      cnt  <= cnt_next;
    end
  end

  assign busy_cnt = cnt;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] val;
    logic                  bsy;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      val = regs[ra];
      bsy = busy[ra];
      if (!valid_addr(ra)) begin
        val = '0;
        bsy = 1'b0;
      end else if (BYPASS && wr_hit[ra]) begin
        val = wr_val[ra];
        bsy = set_mask[ra];
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = val;
    assign rbusy[i]                          = bsy;
  end

endmodule
